// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer: register offsets, CTRL/STATUS bit
// positions, the CTRL field layout and the byte-strobe merge helper.
package apb_timer_pkg;

  localparam logic [3:0] TMR_CTRL     = 4'd0;
  localparam logic [3:0] TMR_PRESCALE = 4'd1;
  localparam logic [3:0] TMR_RELOAD   = 4'd2;
  localparam logic [3:0] TMR_COUNT    = 4'd3;
  localparam logic [3:0] TMR_COMPARE  = 4'd4;
  localparam logic [3:0] TMR_STATUS   = 4'd5;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_OVF_IE  = 2;
  localparam int CTRL_CMP_IE  = 3;

  localparam int STAT_OVF = 0;
  localparam int STAT_CMP = 1;

  typedef struct packed {
    logic cmp_ie;
    logic ovf_ie;
    logic oneshot;
    logic en;
  } ctrl_t;

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_timer_prescaler.sv
// Prescaler for the APB timer: emits a one-cycle tick every presc+1 enabled
// cycles; the phase counter is held at zero while disabled.
module apb_timer_prescaler
  import apb_timer_pkg::*;
#(
  parameter int PRESC_W = 16
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick_o
);

  logic [PRESC_W-1:0] pcnt_q;
  logic [PRESC_W-1:0] pcnt_d;
  logic               wrap_s;

  // '>=' so that lowering PRESCALE below the current phase wraps at once.
  assign wrap_s = (pcnt_q >= presc);
  assign tick_o = en & wrap_s;

  always_comb begin
    pcnt_d = pcnt_q;
    if (!en) begin
      pcnt_d = '0;
    end else if (wrap_s) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/apb_timer.sv
// APB4 timer peripheral: zero-wait-state register file, prescaled 32-bit
// down-counter with auto-reload/one-shot, compare match and level IRQ.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int PDATA_SIZE = 32,
  parameter int CNT_W      = 32,
  parameter int PRESC_W    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [3:0]            PSTRB,
  input  logic [3:0]            PADDR,
  input  logic [PDATA_SIZE-1:0] PWDATA,
  output logic [PDATA_SIZE-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  irq_o
);

  ctrl_t              ctrl_q, ctrl_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   reload_q, reload_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   compare_q, compare_d;
  logic               ovf_q, ovf_d;
  logic               cmp_q, cmp_d;
  logic               irq_q, irq_d;

  logic               tick_s;
  logic               mapped_s;
  logic               wr_en_s;
  logic               count_wr_s;
  logic               status_wr_s;
  logic [31:0]        reg_rd_s;
  logic [31:0]        wdata_s;
  logic [1:0]         w1c_s;
  logic               ovf_set_s;
  logic               cmp_set_s;

  apb_timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .en      (ctrl_q.en),
    .presc   (presc_q),
    .tick_o  (tick_s)
  );

  assign mapped_s    = (PADDR <= TMR_STATUS);
  assign wr_en_s     = PSEL & PENABLE & PWRITE & mapped_s;
  assign count_wr_s  = wr_en_s & (PADDR == TMR_COUNT);
  assign status_wr_s = wr_en_s & (PADDR == TMR_STATUS);
  assign w1c_s       = PWDATA[1:0] & {2{PSTRB[0]}};
  assign wdata_s     = apply_strb(reg_rd_s, PWDATA, PSTRB);

  assign PRDATA  = (PSEL & ~PWRITE) ? reg_rd_s : 32'd0;
  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & ~mapped_s;
  assign irq_o   = irq_q;

  // Register read mux, zero-extended; also the base for strobed writes.
  always_comb begin
    reg_rd_s = 32'd0;
    case (PADDR)
      TMR_CTRL:     reg_rd_s = {28'd0, ctrl_q};
      TMR_PRESCALE: reg_rd_s = 32'(presc_q);
      TMR_RELOAD:   reg_rd_s = 32'(reload_q);
      TMR_COUNT:    reg_rd_s = 32'(count_q);
      TMR_COMPARE:  reg_rd_s = 32'(compare_q);
      TMR_STATUS:   reg_rd_s = {30'd0, cmp_q, ovf_q};
      default:      reg_rd_s = 32'd0;
    endcase
  end

  // Counter, register writes and status flags; software writes override the tick.
  always_comb begin
    ctrl_d    = ctrl_q;
    presc_d   = presc_q;
    reload_d  = reload_q;
    count_d   = count_q;
    compare_d = compare_q;
    ovf_set_s = 1'b0;
    cmp_set_s = 1'b0;

    if (tick_s && !count_wr_s) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        ovf_set_s = 1'b1;
        if (ctrl_q.oneshot) begin
          ctrl_d.en = 1'b0;
          count_d   = '0;
        end else begin
          count_d = reload_q;
        end
      end
      cmp_set_s = (count_d == compare_q);
    end else begin
      cmp_set_s = 1'b0;
    end

    if (wr_en_s) begin
      case (PADDR)
        TMR_CTRL:     ctrl_d    = ctrl_t'(wdata_s[3:0]);
        TMR_PRESCALE: presc_d   = wdata_s[PRESC_W-1:0];
        TMR_RELOAD:   reload_d  = wdata_s[CNT_W-1:0];
        TMR_COUNT:    count_d   = wdata_s[CNT_W-1:0];
        TMR_COMPARE:  compare_d = wdata_s[CNT_W-1:0];
        default:      ctrl_d    = ctrl_d;
      endcase
    end else begin
      ctrl_d = ctrl_d;
    end

    // A hardware set in the same cycle as a W1C keeps the flag.
    if (status_wr_s) begin
      ovf_d = (ovf_q & ~w1c_s[STAT_OVF]) | ovf_set_s;
      cmp_d = (cmp_q & ~w1c_s[STAT_CMP]) | cmp_set_s;
    end else begin
      ovf_d = ovf_q | ovf_set_s;
      cmp_d = cmp_q | cmp_set_s;
    end

    irq_d = (ovf_q & ctrl_q.ovf_ie) | (cmp_q & ctrl_q.cmp_ie);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      ctrl_q    <= '0;
      presc_q   <= '0;
      reload_q  <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ovf_q     <= 1'b0;
      cmp_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      presc_q   <= presc_d;
      reload_q  <= reload_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ovf_q     <= ovf_d;
      cmp_q     <= cmp_d;
      irq_q     <= irq_d;
    end
  end

endmodule
